// File: rtl/mux_input_conditioner.sv
// Purpose: synchronize and debounce ten raw switch bits (8 data, 2 select) feeding the 4:1 x 2-bit mux.
// Latency: 2 sync cycles + DB_CYCLES debounce cycles, clean edge to a_o/s_o; upd pulses in that same first cycle.
// Backpressure: none; free-running and always accepting. Optional auto-scan select is enabled by defining AUTO_SCAN_EN.
module mux_input_conditioner #(
    parameter int DB_CYCLES = 20000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_a,
    input  logic [1:0] sw_s,
    input  logic       scan_mode,
    output logic [7:0] a_o,
    output logic [1:0] s_o,
    output logic       upd
);

    localparam int NB = 10;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Bit layout for every per-bit vector: [7:0] data switches, [9:8] select switches.
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] stable_q;
    logic [NB-1:0] stable_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [1:0]    s_q;
    logic [1:0]    s_d;
    logic          upd_q;
    logic          upd_d;

    assign raw = {sw_s, sw_a};

    // Two-flop synchronizer on every raw switch bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a bit must differ from its stable value for DB_CYCLES straight cycles.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state registers; reset discards any partial count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef AUTO_SCAN_EN
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic          scan1_q;
    logic          scan2_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [1:0]    scnt_q;
    logic [1:0]    scnt_d;

    // scan_mode is an async level too, so it gets the same two-flop treatment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan1_q <= 1'b0;
            scan2_q <= 1'b0;
        end else begin
            scan1_q <= scan_mode;
            scan2_q <= scan1_q;
        end
    end

    // Divider and select counter run only in scan mode and sit at 0 otherwise,
    // so every entry into scan mode starts cleanly from select 0.
    always_comb begin
        div_d  = '0;
        scnt_d = '0;
        if (scan2_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                scnt_d = scnt_q + 2'd1;
            end else begin
                div_d  = div_q + DW'(1);
                scnt_d = scnt_q;
            end
        end
    end

    // Scan divider and select counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            scnt_q <= '0;
        end else begin
            div_q  <= div_d;
            scnt_q <= scnt_d;
        end
    end

    // Select source: scan counter while scanning, debounced sw_s otherwise.
    always_comb begin
        s_d = scan2_q ? scnt_q : stable_d[9:8];
    end
`else
    logic unused_cfg;
    assign unused_cfg = scan_mode ^ (SCAN_DIV < 1);

    // Select is always the debounced sw_s.
    always_comb begin
        s_d = stable_d[9:8];
    end
`endif

    // Change detect on the next visible values so upd lines up with the new outputs.
    always_comb begin
        upd_d = ({stable_d[7:0], s_d} != {stable_q[7:0], s_q});
    end

    // Output select and update-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            upd_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            upd_q <= upd_d;
        end
    end

    assign a_o = stable_q[7:0];
    assign s_o = s_q;
    assign upd = upd_q;

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Directed bench for mux_input_conditioner with DB_CYCLES=4, SCAN_DIV=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_mux_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw_a;
    logic [1:0] sw_s;
    logic       scan_mode;
    logic [7:0] a_o;
    logic [1:0] s_o;
    logic       upd;

    int checks;
    int failures;

    mux_input_conditioner #(
        .DB_CYCLES(4),
        .SCAN_DIV (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_a     (sw_a),
        .sw_s     (sw_s),
        .scan_mode(scan_mode),
        .a_o      (a_o),
        .s_o      (s_o),
        .upd      (upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        sw_a      = 8'h00;
        sw_s      = 2'b00;
        scan_mode = 1'b0;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_a", 16'(a_o), 16'h00);
        check("rst_s", 16'(s_o), 16'h0);
        check("rst_upd", 16'(upd), 16'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: clean edge, A5/10 visible on cycle 6 with a single upd
        sw_a = 8'hA5;
        sw_s = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t1_a", 16'(a_o), (k >= 6) ? 16'hA5 : 16'h00);
            check("t1_s", 16'(s_o), (k >= 6) ? 16'h2 : 16'h0);
            check("t1_upd", 16'(upd), (k == 6) ? 16'h1 : 16'h0);
        end

        // 2: settle to zero, then a 3-cycle glitch on sw_a[3] must be rejected
        sw_a = 8'h00;
        sw_s = 2'b00;
        repeat (10) tick();
        check("t2_base_a", 16'(a_o), 16'h00);
        check("t2_base_s", 16'(s_o), 16'h0);
        sw_a = 8'h08;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t2_glitch_a", 16'(a_o), 16'h00);
        end
        sw_a = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t2_after_a", 16'(a_o), 16'h00);
            check("t2_after_upd", 16'(upd), 16'h0);
        end

        // 3: all data and select bits flip together -> one update
        sw_a = 8'hFF;
        sw_s = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t3_a", 16'(a_o), (k >= 6) ? 16'hFF : 16'h00);
            check("t3_s", 16'(s_o), (k >= 6) ? 16'h3 : 16'h0);
            check("t3_upd", 16'(upd), (k == 6) ? 16'h1 : 16'h0);
        end

        // 4: reset mid-count discards progress
        sw_a = 8'h00;
        sw_s = 2'b00;
        repeat (10) tick();
        check("t4_base_a", 16'(a_o), 16'h00);
        sw_a = 8'h01;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_a", 16'(a_o), 16'h00);
        check("t4_rst_upd", 16'(upd), 16'h0);
        tick();
        check("t4_rst_hold_a", 16'(a_o), 16'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t4_a", 16'(a_o), (k >= 6) ? 16'h01 : 16'h00);
            check("t4_upd", 16'(upd), (k == 6) ? 16'h1 : 16'h0);
        end

        // Common setup for select tests: sw_s=01 debounced
        sw_s = 2'b01;
        repeat (10) tick();
        check("t5_base_s", 16'(s_o), 16'h1);

`ifdef AUTO_SCAN_EN
        // 5: auto-scan steps 0,1,2,3,0 every 3 cycles, then returns to sw_s
        begin
            int s_exp [15] = '{1, 1, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
            int u_exp [15] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
            int s_out [4]  = '{0, 0, 1, 1};
            int u_out [4]  = '{0, 0, 1, 0};
            scan_mode = 1'b1;
            for (int k = 0; k < 15; k++) begin
                tick();
                check("t5_scan_s", 16'(s_o), 16'(s_exp[k]));
                check("t5_scan_upd", 16'(upd), 16'(u_exp[k]));
            end
            scan_mode = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("t5_exit_s", 16'(s_o), 16'(s_out[k]));
                check("t5_exit_upd", 16'(upd), 16'(u_out[k]));
            end
        end
`else
        // 6: scan_mode has no effect without the scan feature
        for (int k = 1; k <= 12; k++) begin
            scan_mode = ~scan_mode;
            tick();
            check("t6_s", 16'(s_o), 16'h1);
            check("t6_upd", 16'(upd), 16'h0);
            check("t6_a", 16'(a_o), 16'h01);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
